// File: rtl/stopwatch_timebase_counter_pkg.sv
// stopwatch_timebase_counter_pkg: shared widths, FSM encoding and digit limits for the stopwatch
package stopwatch_timebase_counter_pkg;

  localparam int BCD_W      = 4;
  localparam int DIGITS     = 6;
  localparam int CNT_W      = BCD_W * DIGITS;
  localparam int S_TENS_IDX = 3;
  localparam int M_TENS_IDX = 5;

  localparam logic [BCD_W-1:0] DEC_MAX    = 4'd9;
  localparam logic [BCD_W-1:0] S_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

  // Digit index 0 is cs_ones, 5 is m_tens; seconds-tens stops at 5, minutes-tens is configurable.
  function automatic logic [BCD_W-1:0] digit_max(input int idx, input int m_tens_max);
    return idx == M_TENS_IDX ? BCD_W'(m_tens_max) : idx == S_TENS_IDX ? S_TENS_MAX : DEC_MAX;
  endfunction

endpackage

// File: rtl/stopwatch_timebase_counter_bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit counting 0..MAX with a combinational carry for chaining
module bcd_digit_counter
  import stopwatch_timebase_counter_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_q, q_d;

  // Next digit value: clear wins, otherwise step and roll over at MAX.
  always_comb begin
    q_d = clr ? '0 : inc ? (q_q == MAX ? '0 : q_q + 4'd1) : q_q;
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/stopwatch_timebase_counter.sv
// stopwatch_timebase_counter: BCD MM:SS.cc stopwatch with run/pause/idle/full FSM and lap freeze
module stopwatch_timebase_counter
  import stopwatch_timebase_counter_pkg::*;
#(
  parameter int MAX_MIN_TENS = 5,
  parameter bit SAT_HOLD     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  output logic [CNT_W-1:0] disp_bcd,
  output logic             running,
  output logic             lap_frozen,
  output logic             full_scale
);

  state_e           state_q, state_d;
  logic             lap_q, lap_d, first_q, running_q, full_q;
  logic [CNT_W-1:0] count, snap_q, disp_q, disp_d;
  logic [DIGITS:0]  chain;
  logic [DIGITS-1:0] at_max;
  logic             in_run, at_full, sat, clr, live, unused_carry;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_counter #(.MAX(digit_max(i, MAX_MIN_TENS))) u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (chain[i]),
      .q     (count[BCD_W*i +: BCD_W]),
      .carry (chain[i+1])
    );
    assign at_max[i] = count[BCD_W*i +: BCD_W] == digit_max(i, MAX_MIN_TENS);
  end

  assign unused_carry = chain[DIGITS];
  assign in_run       = state_q == ST_RUN;
  assign at_full      = &at_max;
  // A tick at full scale either saturates (hold) or is let through to wrap the whole chain.
  assign sat          = SAT_HOLD && in_run && tick && at_full;
  assign chain[0]     = in_run & tick & ~(SAT_HOLD & at_full);
  assign clr          = clear & (state_q == ST_PAUSE | state_q == ST_FULL);

  // Next state, lap freeze flag and display source.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start_stop ? ST_RUN : ST_IDLE;
      ST_RUN:   state_d = sat ? ST_FULL : start_stop ? ST_PAUSE : ST_RUN;
      ST_PAUSE: state_d = clear ? ST_IDLE : start_stop ? ST_RUN : ST_PAUSE;
      ST_FULL:  state_d = clear ? ST_IDLE : ST_FULL;
      default:  state_d = ST_IDLE;
    endcase
    lap_d  = in_run ? (lap_q ^ lap) & ~sat : state_q == ST_PAUSE ? lap_q & ~lap & ~clear : 1'b0;
    // In the first frozen cycle the live count already holds the post-increment value to capture.
    live   = ~lap_q | first_q;
    disp_d = live ? count : snap_q;
  end

  // FSM state, snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lap_q     <= 1'b0;
      first_q   <= 1'b0;
      snap_q    <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_q     <= lap_d;
      first_q   <= lap_d & ~lap_q;
      snap_q    <= disp_d;
      disp_q    <= disp_d;
      running_q <= state_d == ST_RUN;
      full_q    <= state_d == ST_FULL;
    end
  end

  assign disp_bcd   = disp_q;
  assign running    = running_q;
  assign lap_frozen = lap_q;
  assign full_scale = full_q;

endmodule

// File: tb/tb_stopwatch_timebase_counter.sv
// tb_stopwatch_timebase_counter: vector table, corner sequences and random run against a centisecond model
module tb_stopwatch_timebase_counter;

  logic clk, rst, tick, start_stop, clear, lap;
  logic [23:0] disp_o [3];
  logic run_o [3], fz_o [3], fs_o [3];

  int total = 0;
  int bad = 0;

  // dut index 0: full 59:59.99 saturating; 1: full 09:59.99 saturating; 2: full 09:59.99 wrapping
  stopwatch_timebase_counter #(.MAX_MIN_TENS(5), .SAT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .disp_bcd(disp_o[0]), .running(run_o[0]), .lap_frozen(fz_o[0]), .full_scale(fs_o[0]));
  stopwatch_timebase_counter #(.MAX_MIN_TENS(0), .SAT_HOLD(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .disp_bcd(disp_o[1]), .running(run_o[1]), .lap_frozen(fz_o[1]), .full_scale(fs_o[1]));
  stopwatch_timebase_counter #(.MAX_MIN_TENS(0), .SAT_HOLD(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .disp_bcd(disp_o[2]), .running(run_o[2]), .lap_frozen(fz_o[2]), .full_scale(fs_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count kept as plain centiseconds, mode 0 idle, 1 run, 2 pause, 3 full.
  int fullv [3] = '{359999, 59999, 59999};
  bit satv [3] = '{1'b1, 1'b1, 1'b0};
  int mode [3], cnt [3], snap [3];
  bit mfz [3];
  logic [23:0] mdisp [3];

  function automatic logic [23:0] to_bcd(input int v);
    int cs, s, m;
    cs = v % 100;
    s  = (v / 100) % 60;
    m  = v / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0; cnt[i] = 0; snap[i] = 0; mfz[i] = 1'b0; mdisp[i] = '0;
    end
  endtask

  task automatic model_step(input logic s, input logic c, input logic l, input logic t);
    for (int i = 0; i < 3; i++) begin
      bit went_full;
      went_full = 1'b0;
      mdisp[i] = to_bcd(mfz[i] ? snap[i] : cnt[i]);
      case (mode[i])
        0: if (s) mode[i] = 1;
        1: begin
          if (t) begin
            if (cnt[i] == fullv[i]) begin
              if (satv[i]) begin mode[i] = 3; mfz[i] = 1'b0; went_full = 1'b1; end
              else cnt[i] = 0;
            end else cnt[i] = cnt[i] + 1;
          end
          if (!went_full) begin
            if (l) begin mfz[i] = !mfz[i]; if (mfz[i]) snap[i] = cnt[i]; end
            if (s) mode[i] = 2;
          end
        end
        2: if (c) begin mode[i] = 0; cnt[i] = 0; mfz[i] = 1'b0; end
           else begin if (l) mfz[i] = 1'b0; if (s) mode[i] = 1; end
        default: if (c) begin mode[i] = 0; cnt[i] = 0; end
      endcase
    end
  endtask

  task automatic chk(input string nm, input int i, input logic [23:0] got, input logic [23:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h at %0t", nm, i, got, want, $time);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk("disp", i, disp_o[i], mdisp[i]);
      chk("running", i, 24'(run_o[i]), 24'(mode[i] == 1));
      chk("lap_frozen", i, 24'(fz_o[i]), 24'(mfz[i]));
      chk("full_scale", i, 24'(fs_o[i]), 24'(mode[i] == 3));
    end
  endtask

  // One clock: drive after the falling edge, check 1 time unit after the rising edge.
  task automatic cyc(input logic s, input logic c, input logic l, input logic t);
    start_stop = s; clear = c; lap = l; tick = t;
    @(posedge clk);
    model_step(s, c, l, t);
    #1;
    check_model();
    @(negedge clk);
  endtask

  typedef struct {
    logic s, c, l, t;
    int n;
    logic [23:0] disp;
    logic run, fz;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input logic s, c, l, t, input int n, input logic [23:0] d, input logic r, f);
    vec_t v;
    v.s = s; v.c = c; v.l = l; v.t = t; v.n = n; v.disp = d; v.run = r; v.fz = f;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_disp", i, disp_o[i], 24'h0);
      chk("reset_running", i, 24'(run_o[i]), 24'h0);
      chk("reset_frozen", i, 24'(fz_o[i]), 24'h0);
      chk("reset_full", i, 24'(fs_o[i]), 24'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    add(1,0,0,1,1,     24'h000000,1,0);
    add(0,0,0,0,1,     24'h000000,1,0);
    add(0,0,0,1,150,   24'h000149,1,0);
    add(0,0,0,0,1,     24'h000150,1,0);
    add(0,1,0,0,1,     24'h000150,1,0);
    add(0,0,0,0,1,     24'h000150,1,0);
    add(1,0,0,0,1,     24'h000150,0,0);
    add(0,0,0,1,3,     24'h000150,0,0);
    add(1,1,0,0,1,     24'h000150,0,0);
    add(0,0,0,0,1,     24'h000000,0,0);
    add(1,0,0,0,1,     24'h000000,1,0);
    add(0,0,0,1,37,    24'h000036,1,0);
    add(0,0,1,0,1,     24'h000037,1,1);
    add(0,0,0,1,20,    24'h000037,1,1);
    add(0,0,0,0,1,     24'h000037,1,1);
    add(0,0,1,0,1,     24'h000037,1,0);
    add(0,0,0,0,1,     24'h000057,1,0);
    add(1,1,0,0,1,     24'h000057,0,0);
    add(0,1,0,0,1,     24'h000057,0,0);
    add(0,0,0,0,1,     24'h000000,0,0);
    add(1,0,0,0,1,     24'h000000,1,0);
    add(0,0,0,1,5999,  24'h005998,1,0);
    add(0,0,0,0,1,     24'h005999,1,0);
    add(0,0,0,1,1,     24'h005999,1,0);
    add(0,0,0,0,1,     24'h010000,1,0);
    add(0,0,0,1,53999, 24'h095998,1,0);
    add(0,0,0,0,1,     24'h095999,1,0);
    add(0,0,0,1,1,     24'h095999,1,0);
    add(0,0,0,0,1,     24'h100000,1,0);

    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].n; r++) cyc(tbl[k].s, tbl[k].c, tbl[k].l, tbl[k].t);
      chk("tbl_disp", k, disp_o[0], tbl[k].disp);
      chk("tbl_running", k, 24'(run_o[0]), 24'(tbl[k].run));
      chk("tbl_frozen", k, 24'(fz_o[0]), 24'(tbl[k].fz));
    end

    chk("sat_disp", 1, disp_o[1], 24'h095999);
    chk("sat_full", 1, 24'(fs_o[1]), 24'h1);
    chk("sat_running", 1, 24'(run_o[1]), 24'h0);
    chk("wrap_disp", 2, disp_o[2], 24'h000000);
    chk("wrap_running", 2, 24'(run_o[2]), 24'h1);
    chk("wrap_full", 2, 24'(fs_o[2]), 24'h0);

    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_hold_disp", 1, disp_o[1], 24'h095999);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_ignore_ss", 1, 24'(fs_o[1]), 24'h1);
    chk("sat_ignore_lap", 1, 24'(fz_o[1]), 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_clear_disp", 1, disp_o[1], 24'h000000);
    chk("sat_clear_full", 1, 24'(fs_o[1]), 24'h0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (25) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_async_disp", 0, disp_o[0], 24'h000025);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_disp", 0, disp_o[0], 24'h0);
    chk("async_running", 0, 24'(run_o[0]), 24'h0);
    check_model();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_tick_skipped", 0, disp_o[0], 24'h000000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_counted_tick", 0, disp_o[0], 24'h000001);

    for (int r = 0; r < 4000; r++)
      cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
